// File: rtl/ins_prefetch_queue_if.sv
// Bundle of program-memory bus and decoder-side signals for the instruction
// prefetch queue. The master modport is the queue; the slave modport is the
// surrounding memory/decoder environment.
interface ins_prefetch_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_sel;
  logic [7:0]        mem_data;
  logic              bus_busy;
  logic              ins_valid;
  logic [7:0]        ins_byte;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_pop;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic [LVL_W-1:0]  level;

  modport master (
    output mem_addr, mem_rd, mem_sel, ins_valid, ins_byte, ins_pc, level,
    input  mem_data, bus_busy, ins_pop, flush, flush_pc
  );

  modport slave (
    input  mem_addr, mem_rd, mem_sel, ins_valid, ins_byte, ins_pc, level,
    output mem_data, bus_busy, ins_pop, flush, flush_pc
  );
endinterface

// File: rtl/ins_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential code bytes from program
// memory into a DEPTH-entry FIFO and presents the head byte/address to the
// decoder. Yields to CPU data accesses (bus_busy) and drops everything on flush.
// Optional build macro PREFETCH_STATS_EN adds stat_fetched/stat_flushed counters.
module ins_prefetch_queue #(
  parameter int unsigned       DEPTH       = 4,
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  ins_prefetch_queue_if.master bus
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]          stat_fetched,
  output logic [15:0]          stat_flushed
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [7:0]        data_mem_q [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];

  logic pop;
  logic capture;
  logic push;
  logic room;
  logic issue;

  // Qualified pop/push strobes and the issue test (slot guaranteed at capture)
  always_comb begin
    pop     = bus.ins_pop && (level_q != '0) && !bus.flush;
    capture = (state_q == S_READ) && (cnt_q == '0);
    push    = capture && !bus.flush;
    room    = (level_q - LVL_W'(pop)) < LVL_W'(DEPTH);
    issue   = (state_q == S_IDLE) && !bus.flush && !bus.bus_busy && room;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (issue) state_d = S_READ;
        S_READ:  if (cnt_q == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM/FIFO outputs; head is read straight out of registered storage
  always_comb begin
    bus.mem_rd    = (state_q == S_READ);
    bus.mem_sel   = 1'b0;
    bus.mem_addr  = addr_q;
    bus.ins_valid = (level_q != '0);
    bus.ins_byte  = data_mem_q[rd_ptr_q];
    bus.ins_pc    = addr_mem_q[rd_ptr_q];
    bus.level     = level_q;
  end

  // Fetch address, latched bus address and wait counter next values
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    if (issue) begin
      addr_d = fetch_pc_q;
      cnt_d  = CNT_W'(WAIT_CYCLES - 1);
    end else if ((state_q == S_READ) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (bus.flush) begin
      fetch_pc_d = bus.flush_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  // FIFO pointer and occupancy next values
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // Datapath and FIFO control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage: byte plus the address it was fetched from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= RESET_PC;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= bus.mem_data;
      addr_mem_q[wr_ptr_q] <= addr_q;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [15:0] fetched_q, fetched_d;
  logic [15:0] flushed_q, flushed_d;
  logic        flush_hit;

  // Saturating counters: bytes pushed, and flushes that discarded something
  always_comb begin
    flush_hit = bus.flush && ((level_q != '0) || (state_q == S_READ));
    fetched_d = fetched_q;
    flushed_d = flushed_q;
    if (push && (fetched_q != 16'hFFFF))      fetched_d = fetched_q + 16'd1;
    if (flush_hit && (flushed_q != 16'hFFFF)) flushed_d = flushed_q + 16'd1;
  end

  // Statistics registers, cleared only by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_ins_prefetch_queue.sv
// Directed bench for ins_prefetch_queue: memory returns addr[7:0]^8'hA5.
module tb_ins_prefetch_queue;
  localparam int unsigned       DEPTH       = 4;
  localparam int unsigned       ADDR_W      = 16;
  localparam int unsigned       WAIT_CYCLES = 1;
  localparam logic [ADDR_W-1:0] RESET_PC    = 16'h0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ins_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_flushed;
`endif

  ins_prefetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  assign bus.mem_data = bus.mem_addr[7:0] ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst          = 1'b1;
    bus.bus_busy = 1'b0;
    bus.ins_pop  = 1'b0;
    bus.flush    = 1'b0;
    bus.flush_pc = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
    n_checks++; if (bus.mem_sel !== 1'b0) begin n_fail++; $display("FAIL reset_mem_sel: got %b expected 0", bus.mem_sel); end
    n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
    n_checks++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ins_valid: got %b expected 0", bus.ins_valid); end
    n_checks++; if (bus.ins_byte !== 8'h00) begin n_fail++; $display("FAIL reset_ins_byte: got %h expected 00", bus.ins_byte); end
    n_checks++; if (bus.ins_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_ins_pc: got %h expected 0000", bus.ins_pc); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
  endtask

  // Fill after reset: four reads 0000..0003, then stop at level 4
  task automatic test_fill();
    logic [15:0] got_q[$];
    logic        prev;
    logic [15:0] exp_a;
    prev = 1'b0;
    rst  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_rd && !prev) got_q.push_back(bus.mem_addr);
      prev = bus.mem_rd;
    end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL fill_read_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_a = 16'(i);
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_a) begin
        n_fail++; $display("FAIL fill_read_addr[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_a);
      end
    end
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d expected 4", bus.level); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL fill_no_rd: got %b expected 0", bus.mem_rd); end
    n_checks++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b expected 1", bus.ins_valid); end
    n_checks++; if (bus.ins_byte !== 8'hA5) begin n_fail++; $display("FAIL fill_head_byte: got %h expected a5", bus.ins_byte); end
    n_checks++; if (bus.ins_pc !== 16'h0000) begin n_fail++; $display("FAIL fill_head_pc: got %h expected 0000", bus.ins_pc); end
`ifdef PREFETCH_STATS_EN
    n_checks++; if (stat_fetched !== 16'd4) begin n_fail++; $display("FAIL fill_stat_fetched: got %0d expected 4", stat_fetched); end
    n_checks++; if (stat_flushed !== 16'd0) begin n_fail++; $display("FAIL fill_stat_flushed: got %0d expected 0", stat_flushed); end
`endif
  endtask

  // Pop four in a row from a full queue; refetch begins at 0004
  task automatic test_pop();
    logic        seen;
    logic [15:0] first_a;
    logic [7:0]  exp_b;
    seen    = 1'b0;
    first_a = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      bus.ins_pop = 1'b1;
      exp_b = 8'(i) ^ 8'hA5;
      n_checks++; if (bus.ins_byte !== exp_b) begin n_fail++; $display("FAIL pop_byte[%0d]: got %h expected %h", i, bus.ins_byte, exp_b); end
      n_checks++; if (bus.ins_pc !== 16'(i)) begin n_fail++; $display("FAIL pop_pc[%0d]: got %h expected %h", i, bus.ins_pc, 16'(i)); end
      @(negedge clk);
      if (bus.mem_rd && !seen) begin seen = 1'b1; first_a = bus.mem_addr; end
      n_checks++; if (bus.level > 3'd4 || bus.level === 3'd0) begin n_fail++; $display("FAIL pop_level_range[%0d]: got %0d expected 1..4", i, bus.level); end
    end
    bus.ins_pop = 1'b0;
    n_checks++; if (!seen || first_a !== 16'h0004) begin n_fail++; $display("FAIL pop_refetch_addr: got %h expected 0004", first_a); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++; if (bus.level > 3'd4) begin n_fail++; $display("FAIL pop_level_max[%0d]: got %0d expected <=4", c, bus.level); end
    end
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL pop_refill_level: got %0d expected 4", bus.level); end
    n_checks++; if (bus.ins_pc !== 16'h0004) begin n_fail++; $display("FAIL pop_new_head_pc: got %h expected 0004", bus.ins_pc); end
    n_checks++; if (bus.ins_byte !== 8'hA1) begin n_fail++; $display("FAIL pop_new_head_byte: got %h expected a1", bus.ins_byte); end
  endtask

  // bus_busy raised during the read at 0005: read finishes, no new issue until released
  task automatic test_bus_busy();
    bus.flush    = 1'b1;
    bus.flush_pc = 16'h0005;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL busy_flush_level: got %0d expected 0", bus.level); end
    @(negedge clk);
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0005) begin n_fail++; $display("FAIL busy_read5: got rd=%b addr=%h expected rd=1 addr=0005", bus.mem_rd, bus.mem_addr); end
    bus.bus_busy = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL busy_push_level: got %0d expected 1", bus.level); end
    n_checks++; if (bus.ins_pc !== 16'h0005) begin n_fail++; $display("FAIL busy_push_pc: got %h expected 0005", bus.ins_pc); end
    n_checks++; if (bus.ins_byte !== 8'hA0) begin n_fail++; $display("FAIL busy_push_byte: got %h expected a0", bus.ins_byte); end
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL busy_no_rd[%0d]: got %b expected 0", c, bus.mem_rd); end
      @(negedge clk);
    end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL busy_no_rd_last: got %b expected 0", bus.mem_rd); end
    bus.bus_busy = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0006) begin n_fail++; $display("FAIL busy_resume: got rd=%b addr=%h expected rd=1 addr=0006", bus.mem_rd, bus.mem_addr); end
  endtask

  // Flush on the last cycle of the read at 0007; also a pop on an empty queue
  task automatic test_flush_inflight();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_addr == 16'h0007) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL flush_wait_read7: got none expected read at 0007"); end
    bus.flush    = 1'b1;
    bus.flush_pc = 16'h1234;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", bus.ins_valid); end
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL flush_rd_drop: got %b expected 0", bus.mem_rd); end
    bus.ins_pop = 1'b1;
    @(negedge clk);
    bus.ins_pop = 1'b0;
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL empty_pop_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h1234) begin n_fail++; $display("FAIL flush_restart: got rd=%b addr=%h expected rd=1 addr=1234", bus.mem_rd, bus.mem_addr); end
    @(negedge clk);
    n_checks++; if (bus.ins_valid !== 1'b1) begin n_fail++; $display("FAIL flush_first_valid: got %b expected 1", bus.ins_valid); end
    n_checks++; if (bus.ins_pc !== 16'h1234) begin n_fail++; $display("FAIL flush_first_pc: got %h expected 1234", bus.ins_pc); end
    n_checks++; if (bus.ins_byte !== 8'h91) begin n_fail++; $display("FAIL flush_first_byte: got %h expected 91", bus.ins_byte); end
    n_checks++; if (bus.level !== 3'd1) begin n_fail++; $display("FAIL flush_first_level: got %0d expected 1", bus.level); end
  endtask

`ifdef PREFETCH_STATS_EN
  // Flush held 3 cycles: only the first edge discards anything
  task automatic test_stats();
    n_checks++; if (stat_fetched !== 16'd11) begin n_fail++; $display("FAIL stats_fetched: got %0d expected 11", stat_fetched); end
    n_checks++; if (stat_flushed !== 16'd2) begin n_fail++; $display("FAIL stats_flushed: got %0d expected 2", stat_flushed); end
    bus.flush    = 1'b1;
    bus.flush_pc = 16'h2000;
    repeat (3) @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (stat_flushed !== 16'd3) begin n_fail++; $display("FAIL stats_idle_flush: got %0d expected 3", stat_flushed); end
    n_checks++; if (stat_fetched !== 16'd11) begin n_fail++; $display("FAIL stats_fetched_hold: got %0d expected 11", stat_fetched); end
  endtask
`endif

  // Restart at FFFE: fetch address wraps through 0000
  task automatic test_wrap();
    logic [15:0] got_q[$];
    logic [15:0] exp_a[4];
    logic        prev;
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    bus.flush    = 1'b1;
    bus.flush_pc = 16'hFFFE;
    @(negedge clk);
    bus.flush = 1'b0;
    prev = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.mem_rd && !prev) got_q.push_back(bus.mem_addr);
      prev = bus.mem_rd;
    end
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL wrap_read_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i] !== exp_a[i]) begin
        n_fail++; $display("FAIL wrap_read_addr[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_a[i]);
      end
    end
    n_checks++; if (bus.level !== 3'd4) begin n_fail++; $display("FAIL wrap_level: got %0d expected 4", bus.level); end
    for (int i = 0; i < 4; i++) begin
      bus.ins_pop = 1'b1;
      n_checks++; if (bus.ins_pc !== exp_a[i]) begin n_fail++; $display("FAIL wrap_head_pc[%0d]: got %h expected %h", i, bus.ins_pc, exp_a[i]); end
      @(negedge clk);
    end
    bus.ins_pop = 1'b0;
  endtask

  // Asynchronous reset in the middle of a read
  task automatic test_async_reset();
    logic found;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_rd) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL arst_wait_read: got none expected a read"); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL arst_mem_rd: got %b expected 0", bus.mem_rd); end
    n_checks++; if (bus.level !== 3'd0) begin n_fail++; $display("FAIL arst_level: got %0d expected 0", bus.level); end
    n_checks++; if (bus.ins_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", bus.ins_valid); end
    n_checks++; if (bus.mem_addr !== RESET_PC) begin n_fail++; $display("FAIL arst_mem_addr: got %h expected %h", bus.mem_addr, RESET_PC); end
`ifdef PREFETCH_STATS_EN
    n_checks++; if (stat_fetched !== 16'd0) begin n_fail++; $display("FAIL arst_stat_fetched: got %0d expected 0", stat_fetched); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill();
    test_pop();
    test_bus_busy();
    test_flush_inflight();
`ifdef PREFETCH_STATS_EN
    test_stats();
`endif
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
